// File: rtl/reset_sequencer.sv
// Reset sequencer: merges watchdog, external-pin and power-on resets, stretches the
// request to a minimum width, then releases peripherals first and the CPU core later.
module reset_sequencer #(
    parameter int unsigned STRETCH     = 16,
    parameter int unsigned CPU_DELAY   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       power_on_reset_n,
    input  logic       wdt_reset,
    input  logic       ext_reset_n,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       in_reset,
    output logic [1:0] reset_cause
);

    localparam int unsigned MAX_CNT = (STRETCH > CPU_DELAY) ? STRETCH : CPU_DELAY;
    localparam int unsigned CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH - 1);
    localparam logic [CW-1:0] CPU_LOAD     = CW'(CPU_DELAY - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_WDT = 2'b01;
    localparam logic [1:0] CAUSE_EXT = 2'b10;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   periph_d;
    logic                   cpu_d;
    logic                   in_reset_d;
    logic [1:0]             cause_d;
    logic [SYNC_STAGES-1:0] ext_sync_q;
    logic                   ext_active;
    logic                   req;

    // External pin synchronizer; presets to 1 so the pin reads deasserted out of POR.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            ext_sync_q <= '1;
        end else begin
            ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_reset_n};
        end
    end

    assign ext_active = ~ext_sync_q[SYNC_STAGES-1];
    assign req        = wdt_reset | ext_active;

    // Next-state logic; a request wins in every state and reloads the stretch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        periph_d   = periph_reset;
        cpu_d      = cpu_reset;
        in_reset_d = in_reset;
        cause_d    = reset_cause;

        if (req) begin
            state_d    = ST_ASSERT;
            cnt_d      = STRETCH_LOAD;
            periph_d   = 1'b1;
            cpu_d      = 1'b1;
            in_reset_d = 1'b1;
            cause_d    = ext_active ? CAUSE_EXT : CAUSE_WDT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d  = ST_RELEASE;
                        cnt_d    = CPU_LOAD;
                        periph_d = 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d    = ST_RUN;
                        cpu_d      = 1'b0;
                        in_reset_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    // Unreachable encoding: fall back to a full reset sequence.
                    state_d    = ST_ASSERT;
                    cnt_d      = STRETCH_LOAD;
                    periph_d   = 1'b1;
                    cpu_d      = 1'b1;
                    in_reset_d = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= STRETCH_LOAD;
            periph_reset <= 1'b1;
            cpu_reset    <= 1'b1;
            in_reset     <= 1'b1;
            reset_cause  <= CAUSE_POR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            periph_reset <= periph_d;
            cpu_reset    <= cpu_d;
            in_reset     <= in_reset_d;
            reset_cause  <= cause_d;
        end
    end

    // The CPU must never run while peripherals are still held in reset.
    cpu_after_periph_a: assert property (
        @(posedge clk) disable iff (!power_on_reset_n) !(periph_reset && !cpu_reset)
    );

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (16/8 and 1/1) driven in parallel and
// compared against an "edges since last request" reference model.
module tb_reset_sequencer;

    localparam int S0 = 16;
    localparam int D0 = 8;
    localparam int S1 = 1;
    localparam int D1 = 1;
    localparam int SYNC = 2;
    localparam int AGE_MAX = 1000;
    localparam int LOGN = 8;
    localparam logic [9:0] RST_VEC = 10'b11100_11100;

    logic       clk = 1'b0;
    logic       power_on_reset_n = 1'b0;
    logic       wdt_reset = 1'b0;
    logic       ext_reset_n = 1'b1;
    logic       p0, c0, i0, p1, c1, i1;
    logic [1:0] rc0, rc1;
    logic [9:0] act;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.STRETCH(S0), .CPU_DELAY(D0), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .power_on_reset_n(power_on_reset_n), .wdt_reset(wdt_reset),
        .ext_reset_n(ext_reset_n), .periph_reset(p0), .cpu_reset(c0),
        .in_reset(i0), .reset_cause(rc0)
    );

    reset_sequencer #(.STRETCH(S1), .CPU_DELAY(D1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .power_on_reset_n(power_on_reset_n), .wdt_reset(wdt_reset),
        .ext_reset_n(ext_reset_n), .periph_reset(p1), .cpu_reset(c1),
        .in_reset(i1), .reset_cause(rc1)
    );

    assign act = {p0, c0, i0, rc0, p1, c1, i1, rc1};

    // Reference model: the pin is seen SYNC edges after it is sampled; each request
    // restarts an age counter, and the outputs are thresholds on that age.
    int         age;
    int         edge_no;
    logic [1:0] cause_m;
    logic       ext_log [LOGN];
    logic       ext_old_m;
    logic       req_m;

    assign ext_old_m = (edge_no >= SYNC) ? ext_log[(edge_no - SYNC) % LOGN] : 1'b1;
    assign req_m     = wdt_reset | ~ext_old_m;

    always @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            age     <= 0;
            edge_no <= 0;
            cause_m <= 2'b00;
        end else begin
            ext_log[edge_no % LOGN] <= ext_reset_n;
            edge_no <= edge_no + 1;
            if (req_m) begin
                age     <= 0;
                cause_m <= ext_old_m ? 2'b01 : 2'b10;
            end else if (age < AGE_MAX) begin
                age <= age + 1;
            end
        end
    end

    function automatic logic [9:0] exp_vec();
        return {age < S0, age < S0 + D0, age < S0 + D0, cause_m,
                age < S1, age < S1 + D1, age < S1 + D1, cause_m};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        power_on_reset_n = 1'b0;
        wdt_reset = 1'b0;
        ext_reset_n = 1'b1;
        repeat (3) cyc();
        checks++;
        if (act !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", act, RST_VEC);
        end
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %b want %b", act, exp_vec());
        end
    endtask

    task automatic test_por_release();
        logic [3:0] want;
        #2 power_on_reset_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            want = {e < S0, e < S0 + D0, e < S1, e < S1 + D1};
            checks++;
            if ({p0, c0, p1, c1} !== want) begin
                errors++;
                $display("FAIL por_release edge %0d: got %b want %b", e, {p0, c0, p1, c1}, want);
            end
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL por_model edge %0d: got %b want %b", e, act, exp_vec());
            end
        end
        checks++;
        if ({rc0, rc1, i0, i1} !== 6'b0000_00) begin
            errors++;
            $display("FAIL por_cause: got %b want 000000", {rc0, rc1, i0, i1});
        end
    endtask

    task automatic test_wdt_pulse();
        wdt_reset = 1'b1;
        cyc();
        wdt_reset = 1'b0;
        checks++;
        if ({p0, c0, p1, c1} !== 4'b1111) begin
            errors++;
            $display("FAIL wdt_assert: got %b want 1111", {p0, c0, p1, c1});
        end
        for (int e = 1; e <= 26; e++) begin
            cyc();
            checks++;
            if ({p0, c0} !== {e < S0, e < S0 + D0} || act !== exp_vec()) begin
                errors++;
                $display("FAIL wdt_release edge %0d: got %b want %b", e, act, exp_vec());
            end
        end
        checks++;
        if (rc0 !== 2'b01) begin
            errors++;
            $display("FAIL wdt_cause: got %b want 01", rc0);
        end
    endtask

    task automatic test_ext_reset();
        logic [1:0] want;
        for (int e = 0; e <= 32; e++) begin
            ext_reset_n = (e > 4);
            cyc();
            want = {e >= 2 && e < 22, e >= 2 && e < 30};
            checks++;
            if ({p0, c0} !== want || act !== exp_vec()) begin
                errors++;
                $display("FAIL ext_seq edge %0d: got %b want %b / %b", e, {p0, c0}, want, exp_vec());
            end
        end
        checks++;
        if (rc0 !== 2'b10 || rc1 !== 2'b10) begin
            errors++;
            $display("FAIL ext_cause: got %b %b want 10 10", rc0, rc1);
        end
    endtask

    task automatic test_release_abort();
        logic [1:0] want;
        for (int e = 0; e <= 46; e++) begin
            wdt_reset = (e == 0 || e == 19);
            cyc();
            want = {e < 16 || (e >= 19 && e < 35), e < 43};
            checks++;
            if ({p0, c0} !== want || act !== exp_vec()) begin
                errors++;
                $display("FAIL abort edge %0d: got %b want %b / %b", e, {p0, c0}, want, exp_vec());
            end
        end
        wdt_reset = 1'b0;
    endtask

    task automatic test_both_sources();
        logic [1:0] want;
        for (int e = 0; e <= 30; e++) begin
            ext_reset_n = (e != 0);
            wdt_reset = (e == 2);
            cyc();
            want = {e >= 2 && e < 18, e >= 2 && e < 26};
            checks++;
            if ({p0, c0} !== want || act !== exp_vec()) begin
                errors++;
                $display("FAIL both_seq edge %0d: got %b want %b / %b", e, {p0, c0}, want, exp_vec());
            end
            if (e == 2) begin
                checks++;
                if (rc0 !== 2'b10 || rc1 !== 2'b10) begin
                    errors++;
                    $display("FAIL both_cause: got %b %b want 10 10", rc0, rc1);
                end
            end
        end
        wdt_reset = 1'b0;
        ext_reset_n = 1'b1;
    endtask

    task automatic test_por_mid_release();
        wdt_reset = 1'b1;
        cyc();
        wdt_reset = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            cyc();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL mid_pre edge %0d: got %b want %b", e, act, exp_vec());
            end
        end
        checks++;
        if ({p0, c0} !== 2'b01) begin
            errors++;
            $display("FAIL mid_in_release: got %b want 01", {p0, c0});
        end
        #2 power_on_reset_n = 1'b0;
        #1;
        checks++;
        if (act !== RST_VEC) begin
            errors++;
            $display("FAIL mid_async_reset: got %b want %b", act, RST_VEC);
        end
        cyc();
        cyc();
        #2 power_on_reset_n = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            cyc();
            checks++;
            if ({p0, c0} !== {e < S0, e < S0 + D0} || act !== exp_vec()) begin
                errors++;
                $display("FAIL mid_rerelease edge %0d: got %b want %b", e, act, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int ext_left = 0;
        logic quiet;
        for (int i = 0; i < 3000; i++) begin
            quiet = ((i % 250) >= 200);
            wdt_reset = !quiet && ($urandom_range(0, 59) == 0);
            if (!quiet && ext_left == 0 && $urandom_range(0, 89) == 0)
                ext_left = $urandom_range(1, 6);
            ext_reset_n = (ext_left == 0);
            if (ext_left > 0) ext_left--;
            cyc();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", i, act, exp_vec());
            end
        end
        wdt_reset = 1'b0;
        ext_reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_por_release();
        test_wdt_pulse();
        test_ext_reset();
        test_release_abort();
        test_both_sources();
        test_por_mid_release();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
